// File: rtl/pump3_sequencer.sv
// Six-phase peristaltic sequencer for a three-valve pneumatic pump.
// Each phase lasts max(phase_len,1) cycles; runs execute a latched number of strokes.
module pump3_sequencer #(
  parameter int PHASE_W = 16,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               dir,
  input  logic [CNT_W-1:0]   strokes,
  input  logic [PHASE_W-1:0] phase_len,
  input  logic               abort,
  output logic               pump1,
  output logic               pump2,
  output logic               pump3,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   strokes_left
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [PHASE_W-1:0] ONE_P = PHASE_W'(1);
  localparam logic [CNT_W-1:0]   ONE_C = CNT_W'(1);

  state_t             state_q, state_d;
  logic [2:0]         phase_q, phase_d;
  logic [PHASE_W-1:0] timer_q, timer_d;
  logic [PHASE_W-1:0] len_q, len_d;
  logic               dir_q, dir_d;
  logic [CNT_W-1:0]   left_d;
  logic [2:0]         pumps_d;
  logic               busy_d, done_d;

  function automatic logic [2:0] pattern(input logic [2:0] ph, input logic rev);
    logic [2:0] p;
    p = 3'b111;
    if (!rev) begin
      case (ph)
        3'd0: p = 3'b101;
        3'd1: p = 3'b001;
        3'd2: p = 3'b011;
        3'd3: p = 3'b010;
        3'd4: p = 3'b110;
        3'd5: p = 3'b100;
        default: p = 3'b111;
      endcase
    end else begin
      case (ph)
        3'd0: p = 3'b101;
        3'd1: p = 3'b100;
        3'd2: p = 3'b110;
        3'd3: p = 3'b010;
        3'd4: p = 3'b011;
        3'd5: p = 3'b001;
        default: p = 3'b111;
      endcase
    end
    return p;
  endfunction

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    timer_d = timer_q;
    len_d   = len_q;
    dir_d   = dir_q;
    left_d  = strokes_left;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          dir_d   = dir;
          len_d   = (phase_len == '0) ? ONE_P : phase_len;
          phase_d = 3'd0;
          timer_d = '0;
          if (strokes == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            left_d  = strokes;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          phase_d = 3'd0;
          timer_d = '0;
          left_d  = '0;
        end else if (timer_q == len_q - ONE_P) begin
          timer_d = '0;
          if (phase_q == 3'd5) begin
            phase_d = 3'd0;
            if (strokes_left == ONE_C) begin
              state_d = IDLE;
              left_d  = '0;
              done_d  = 1'b1;
            end else begin
              left_d = strokes_left - ONE_C;
            end
          end else begin
            phase_d = phase_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + ONE_P;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are derived from the next state so they register in step with it.
    busy_d  = (state_d == RUN);
    pumps_d = (state_d == RUN) ? pattern(phase_d, dir_d) : 3'b111;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      phase_q      <= 3'd0;
      timer_q      <= '0;
      len_q        <= ONE_P;
      dir_q        <= 1'b0;
      strokes_left <= '0;
      pump1        <= 1'b1;
      pump2        <= 1'b1;
      pump3        <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      timer_q      <= timer_d;
      len_q        <= len_d;
      dir_q        <= dir_d;
      strokes_left <= left_d;
      pump1        <= pumps_d[2];
      pump2        <= pumps_d[1];
      pump3        <= pumps_d[0];
      busy         <= busy_d;
      done         <= done_d;
    end
  end

endmodule

// File: tb/tb_pump3_sequencer.sv
// Randomized and directed checks of pump3_sequencer against a queue-based
// model that expands each accepted run into its expected per-cycle outputs.
module tb_pump3_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, dir, abort;
  logic [7:0]  strokes;
  logic [15:0] phase_len;
  logic        pump1, pump2, pump3, busy, done;
  logic [7:0]  strokes_left;

  int unsigned checks = 0;
  int unsigned errors = 0;

  pump3_sequencer #(.PHASE_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .strokes(strokes),
    .phase_len(phase_len), .abort(abort), .pump1(pump1), .pump2(pump2),
    .pump3(pump3), .busy(busy), .done(done), .strokes_left(strokes_left)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] p;
    logic       busy;
    logic       done;
    logic [7:0] left;
  } exp_t;

  localparam exp_t IDLE_E = '{p: 3'b111, busy: 1'b0, done: 1'b0, left: 8'd0};
  localparam exp_t DONE_E = '{p: 3'b111, busy: 1'b0, done: 1'b1, left: 8'd0};

  logic [2:0] fwd_tbl [6] = '{3'b101, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100};
  logic [2:0] rev_tbl [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

  exp_t q[$];
  logic in_run = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle(input logic s, input logic d, input logic [7:0] n,
                       input logic [15:0] l, input logic a, input logic r);
    exp_t e;
    int unsigned eff;
    start = s; dir = d; strokes = n; phase_len = l; abort = a; rst = r;
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      e = IDLE_E;
    end else if (in_run) begin
      if (a) begin
        q.delete();
        e = IDLE_E;
      end else begin
        e = q.pop_front();
      end
    end else if (s && !a) begin
      if (n == 8'd0) begin
        e = DONE_E;
      end else begin
        eff = (l == 16'd0) ? 1 : int'(l);
        for (int st = 0; st < int'(n); st++)
          for (int ph = 0; ph < 6; ph++)
            for (int c = 0; c < int'(eff); c++)
              q.push_back('{p: d ? rev_tbl[ph] : fwd_tbl[ph], busy: 1'b1,
                            done: 1'b0, left: n - 8'(st)});
        q.push_back(DONE_E);
        e = q.pop_front();
      end
    end else begin
      e = IDLE_E;
    end
    in_run = e.busy;
    check("pumps", 32'({pump1, pump2, pump3}), 32'(e.p));
    check("busy", 32'(busy), 32'(e.busy));
    check("done", 32'(done), 32'(e.done));
    check("strokes_left", 32'(strokes_left), 32'(e.left));
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b0);
  endtask

  initial begin
    cycle(1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b1);
    idle(2);
    // forward, 1 stroke, 2 cycles per phase
    cycle(1'b1, 1'b0, 8'd1, 16'd2, 1'b0, 1'b0); idle(14);
    // reverse, 2 strokes, 1 cycle per phase
    cycle(1'b1, 1'b1, 8'd2, 16'd1, 1'b0, 1'b0); idle(14);
    // zero strokes
    cycle(1'b1, 1'b0, 8'd0, 16'd3, 1'b0, 1'b0); idle(3);
    // zero phase length
    cycle(1'b1, 1'b0, 8'd1, 16'd0, 1'b0, 1'b0); idle(8);
    // abort in 4th run cycle, then a normal run
    cycle(1'b1, 1'b0, 8'd3, 16'd1, 1'b0, 1'b0); idle(3);
    cycle(1'b0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0); idle(2);
    cycle(1'b1, 1'b1, 8'd1, 16'd1, 1'b0, 1'b0); idle(8);
    // start changes during run are ignored, then reset mid-run
    cycle(1'b1, 1'b0, 8'd2, 16'd2, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 8'd7, 16'd5, 1'b0, 1'b0);
    idle(4);
    cycle(1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b1); idle(3);
    // start held high across back-to-back runs
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 8'd1, 16'd1, 1'b0, 1'b0);
    idle(8);
    // abort and start together in idle
    cycle(1'b1, 1'b0, 8'd2, 16'd1, 1'b1, 1'b0); idle(3);
    // abort coinciding with final-phase completion
    cycle(1'b1, 1'b0, 8'd1, 16'd1, 1'b0, 1'b0); idle(5);
    cycle(1'b0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0); idle(3);
    // random traffic
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(2) == 0, 1'($urandom), 8'($urandom_range(3)),
            16'($urandom_range(3)), $urandom_range(49) == 0, $urandom_range(149) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pump3_sequencer.md
PUMP3_SEQUENCER -- requirements
Module: pump3_sequencer

Interface
REQ-001 Parameters SHALL be: PHASE_W, default 16, width of phase_len; CNT_W, default 8, width of strokes and strokes_left.
REQ-002 The module SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port rst  input  1  synchronous active-high reset.
REQ-005 Port start  input  1  request a pumping run; sampled only in IDLE.
REQ-006 Port dir  input  1  0 = forward (pump1 to pump3 fluid direction), 1 = reverse; latched at accepted start.
REQ-007 Port strokes  input  CNT_W  number of full 6-phase strokes to execute; latched at accepted start.
REQ-008 Port phase_len  input  PHASE_W  cycles per phase; latched at accepted start; 0 treated as 1.
REQ-009 Port abort  input  1  terminate the current run.
REQ-010 Port pump1, pump2, pump3  output  1 each  pneumatic control lines to a pump3_40px_0 instance; 1 = pressurised (valve closed).
REQ-011 Port busy  output  1  high while in RUN.
REQ-012 Port done  output  1  single-cycle completion pulse.
REQ-013 Port strokes_left  output  CNT_W  strokes remaining, including the current stroke.

Function
REQ-014 The FSM SHALL have the states IDLE and RUN; all outputs SHALL be registered.
REQ-015 In IDLE, {pump1,pump2,pump3} SHALL be 3'b111, so all valves are closed and the channel is isolated.
REQ-016 Forward phase patterns {p1,p2,p3}, phases 0..5, SHALL be: 101, 001, 011, 010, 110, 100.
REQ-017 Reverse phase patterns SHALL be: 101, 100, 110, 010, 011, 001.
REQ-018 Start accepted at edge k with strokes>0 and abort=0: at k+1, busy=1, phase 0 pattern driven, strokes_left=strokes.
REQ-019 Each phase SHALL be held for exactly max(phase_len,1) cycles, counted by an internal phase timer.
REQ-020 After phase 5 completes, the phase SHALL wrap to 0 and strokes_left SHALL decrement in the same cycle.
REQ-021 When the final phase 5 of the last stroke completes, the next cycle SHALL show: IDLE, outputs 111, busy=0, done=1 for that one cycle, strokes_left=0.
REQ-022 Total RUN duration SHALL be 6*strokes*max(phase_len,1) cycles.
REQ-023 Start with strokes=0: no RUN; the next cycle SHALL show done=1 for one cycle, busy=0, and outputs unchanged at 111.
REQ-024 Start asserted while in RUN SHALL be ignored, including any changes to dir, strokes or phase_len.
REQ-025 Abort in RUN: the next cycle SHALL show IDLE, outputs 111, busy=0, done=0, strokes_left=0.
REQ-026 Abort and start together in IDLE: abort wins and the start is discarded.
REQ-027 Abort in the same cycle as final-phase completion: abort wins and done is not pulsed.
REQ-028 Start held high continuously: a new run SHALL be accepted on the first IDLE cycle after done, so there is one idle cycle with outputs 111 between runs.
REQ-029 Internal counters SHALL not wrap during a run; the phase timer width is PHASE_W and the stroke counter width is CNT_W.

Reset
REQ-030 While rst=1 at an edge, the block SHALL enter IDLE with pump1..3=1, busy=0, done=0, strokes_left=0, and phase and timer cleared.
REQ-031 Reset mid-run SHALL discard the run with no done pulse; rst SHALL take priority over start and abort.

Verification
REQ-032 Scenario: start, dir=0, strokes=1, phase_len=2 -> patterns 101,101,001,001,011,011,010,010,110,110,100,100, then 111 with done=1; busy high for exactly 12 cycles.
REQ-033 Scenario: dir=1, strokes=2, phase_len=1 -> sequence 101,100,110,010,011,001 twice; strokes_left 2 then 1; done on cycle 13 after start.
REQ-034 Scenario: strokes=0 -> done=1 on the next cycle, busy never high, outputs constantly 111.
REQ-035 Scenario: phase_len=0, strokes=1 -> behaves as phase_len=1, 6 busy cycles.
REQ-036 Scenario: abort in cycle 4 of a strokes=3 run -> next cycle outputs 111, busy=0, no done; a following start runs normally.
REQ-037 Scenario: rst pulsed mid-run, and start changed during RUN -> immediate IDLE, 111, no done; in-run start changes have no effect on the active run.
